// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, taken-branch squash and
// data-memory req/ack hold for the 5-stage LEGv8 core.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_branch_taken,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0]  XZR       = REG_W'(31);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]    stall_cycles_reg;

  logic mem_acc;
  logic load_use;
  logic mem_stall;
  logic advance;

  assign mem_acc  = mem_memread | mem_memwrite;
  assign load_use = ex_memread && (ex_rd != XZR) &&
                    ((ex_rd == id_rn) || (id_use_rm && (ex_rd == id_rm)));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_stall     = 1'b0;
    advance       = 1'b0;
    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;

    case (state_reg)
      RUN: begin
        dmem_req = mem_acc;
        if (mem_acc && !dmem_ack) begin
          mem_stall     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Request stays up until ack so the memory sees a stable handshake.
        dmem_req = 1'b1;
        if (dmem_ack) begin
          advance    = 1'b1;
          state_next = RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next = ERR;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end
      end
      ERR: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end
      default: state_next = RUN;
    endcase

    if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end

    // A taken branch squashes the dependent instruction, so it beats load-use.
    if (advance) begin
      if (mem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= '0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (!pc_en && (state_reg != ERR) && (stall_cycles_reg != {CNT_W{1'b1}})) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
    end
  end

  assign mem_timeout  = (state_reg == ERR);
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with a scoreboard queue of expected
// outputs and a small saturating model of the stall counter.
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [REG_W-1:0] id_rn, id_rm, ex_rd;
  logic             id_use_rm, ex_memread, mem_memread, mem_memwrite;
  logic             mem_branch_taken, dmem_ack;
  logic             pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_flush, idex_bubble, exmem_flush, memwb_bubble;
  logic             dmem_req, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rm(id_use_rm),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_branch_taken(mem_branch_taken), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  // en = {pc, ifid, idex, exmem}; fl = {ifid_flush, idex_bubble, exmem_flush, memwb_bubble}
  typedef struct packed {
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic             userm;
    logic [REG_W-1:0] rd;
    logic             exmr, mr, mw, br, ack;
    logic [3:0]       en;
    logic [3:0]       fl;
    logic             req, tmo;
  } vec_t;

  vec_t             tbl[$];
  string            tbl_n[$];
  vec_t             sb_q[$];
  int               applied = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_stall = '0;

  function automatic vec_t mk(int rn, int rm, int userm, int rd, int exmr, int mr,
                              int mw, int br, int ack, logic [3:0] en,
                              logic [3:0] fl, int req, int tmo);
    vec_t v;
    v.rn = REG_W'(rn);   v.rm = REG_W'(rm);   v.userm = (userm != 0);
    v.rd = REG_W'(rd);   v.exmr = (exmr != 0);
    v.mr = (mr != 0);    v.mw = (mw != 0);    v.br = (br != 0);
    v.ack = (ack != 0);  v.en = en;           v.fl = fl;
    v.req = (req != 0);  v.tmo = (tmo != 0);
    return v;
  endfunction

  task automatic add(input string nm, input vec_t v);
    tbl.push_back(v);
    tbl_n.push_back(nm);
  endtask

  task automatic drive(input vec_t v);
    id_rn = v.rn;  id_rm = v.rm;  id_use_rm = v.userm;
    ex_rd = v.rd;  ex_memread = v.exmr;
    mem_memread = v.mr;  mem_memwrite = v.mw;
    mem_branch_taken = v.br;  dmem_ack = v.ack;
    sb_q.push_back(v);
  endtask

  task automatic check_out(input string nm);
    vec_t       e;
    logic [9:0] got, want;
    applied++;
    got = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
           exmem_flush, memwb_bubble, dmem_req, mem_timeout};
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: outputs %b but scoreboard empty", nm, got);
      return;
    end
    e = sb_q.pop_front();
    want = {e.en, e.fl, e.req, e.tmo};
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: outputs got %b expected %b", nm, got, want);
    end else begin
      $display("ok   %s: outputs %b", nm, got);
    end
    // Frozen front end counts, except in the error state.
    if (!e.en[3] && !e.tmo && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
  endtask

  task automatic check_stall(input string nm);
    applied++;
    if (stall_cycles !== exp_stall) begin
      miscompares++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", nm, stall_cycles, exp_stall);
    end
  endtask

  task automatic run_one(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check_out(nm);
    @(posedge clk);
    #1;
    check_stall(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, lu, mwv;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0);
    lu   = mk(3, 0, 0, 3, 1, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
    mwv  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0);

    add("idle",          idle);
    add("lu_rn",         lu);
    add("after_lu",      mk(3, 0, 0, 3, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    add("xzr_no_hazard", mk(31, 0, 0, 31, 1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    add("rm_unused",     mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    add("lu_rm",         mk(0, 5, 1, 5, 1, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0));
    add("zero_wait",     mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    add("zero_wait_lu",  mk(7, 0, 0, 7, 1, 1, 0, 0, 1, 4'b0011, 4'b0100, 1, 0));
    add("br_over_lu",    mk(7, 0, 0, 7, 1, 0, 0, 1, 0, 4'b1111, 4'b1110, 0, 0));
    add("ack_noreq",     mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0));
    add("mw_c1",         mwv);
    add("mw_c2_ignore",  mk(2, 0, 0, 2, 1, 1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0));
    add("mw_c3_ack",     mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b1111, 4'b0000, 1, 0));
    add("mw_after",      idle);
    add("mw2_c1",        mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0));
    add("mw2_ack_lu",    mk(4, 0, 0, 4, 1, 0, 1, 0, 1, 4'b0011, 4'b0100, 1, 0));
    add("mw3_c1",        mwv);
    add("mw3_ack_br",    mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 4'b1111, 4'b1110, 1, 0));
    for (int i = 0; i < TIMEOUT + 1; i++)
      add($sformatf("to_c%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0));
    add("err",           mk(6, 0, 0, 6, 1, 0, 1, 1, 1, 4'b0000, 4'b0000, 0, 1));
    add("err_hold",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));
    add("err_hold2",     mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));

    // Reset state while rst_n is still low.
    drive(idle);
    #2;
    check_out("reset");
    check_stall("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_one(tbl_n[i], tbl[i]);

    // Reset pulse clears the sticky error.
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle);
    exp_stall = '0;
    #1;
    check_out("err_reset");
    check_stall("err_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_one("run_after_err", idle);

    // Async reset between edges while in MEM_WAIT.
    run_one("ar_c1", mwv);
    @(negedge clk);
    drive(mwv);
    #1;
    check_out("ar_in_wait");
    #1;
    rst_n = 1'b0;
    drive(idle);
    exp_stall = '0;
    #1;
    check_out("ar_async");
    check_stall("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_one("ar_after", idle);

    // Stall counter saturation.
    for (int i = 0; i < 18; i++) run_one($sformatf("sat_%0d", i), lu);
    applied++;
    if (stall_cycles !== {CNT_W{1'b1}}) begin
      miscompares++;
      $display("FAIL sat_value: stall_cycles got %0d expected %0d", stall_cycles, {CNT_W{1'b1}});
    end
    run_one("sat_release", idle);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARMv8 (LEGv8-subset) core. It drives the enables, bubbles and flushes of every pipeline register.
- Detects load-use hazards between ID and EX, squashes younger instructions on a taken branch resolved in MEM, and holds the pipeline while the data memory completes a req/ack access.
- Sits beside the decoder. Its inputs are the decoder's MemRead/MemWrite/Reg2Loc-derived fields as carried down the pipe.

Parameters:
REG_W, 5, register-index width
TIMEOUT, 15, max MEM_WAIT cycles without ack before error (>=1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
id_rn  in  REG_W  first source register of instruction in ID
id_rm  in  REG_W  second source register after the Reg2Loc select
id_use_rm  in  1  ID instruction actually reads id_rm (0 for immediate/shift forms)
ex_rd  in  REG_W  destination register of instruction in EX
ex_memread  in  1  EX instruction is a load
mem_memread  in  1  MEM instruction is a load
mem_memwrite  in  1  MEM instruction is a store
mem_branch_taken  in  1  branch resolved taken in MEM
dmem_ack  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID register enable
idex_en  out  1  ID/EX register enable
exmem_en  out  1  EX/MEM register enable
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads NOP (control zeroed)
exmem_flush  out  1  EX/MEM loads NOP
memwb_bubble  out  1  MEM/WB loads NOP
dmem_req  out  1  data memory request
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of frozen-front-end cycles

Behaviour:
- FSM states RUN, MEM_WAIT, ERR. Reset (async, rst_n=0): state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
- Outputs are combinational from state and inputs. With idle inputs in RUN:
  - all enables = 1;
  - all flush/bubble = 0;
  - dmem_req = 0.
- mem_acc = mem_memread | mem_memwrite.
- load_use = ex_memread & (ex_rd != 31) & ((ex_rd == id_rn) | (id_use_rm & ex_rd == id_rm)).
  - XZR (31) never creates a hazard.
- RUN priority (highest first):
  1. mem_acc & !dmem_ack:
     - dmem_req = 1;
     - pc_en = ifid_en = idex_en = exmem_en = 0;
     - memwb_bubble = 1;
     - next state MEM_WAIT, wait_cnt <= 0.
  2. mem_acc & dmem_ack:
     - dmem_req = 1, all enables 1;
     - zero-wait access; load_use/branch rules below still apply this cycle.
  3. mem_branch_taken:
     - ifid_flush = idex_bubble = exmem_flush = 1, pc_en = 1;
     - overrides load_use, since the dependent instruction is squashed.
  4. load_use:
     - pc_en = ifid_en = 0, idex_bubble = 1, exmem_en = 1;
     - exactly one bubble per hazard, because next cycle the load is in MEM.
- MEM_WAIT:
  - dmem_req = 1, all enables 0, memwb_bubble = 1, branch and load_use ignored.
  - On dmem_ack: all enables 1, memwb_bubble 0, next RUN. load_use/branch evaluated this same cycle per RUN rules 3–4.
  - No ack and wait_cnt == TIMEOUT-1: next ERR.
  - Otherwise wait_cnt++.
- ERR:
  - all enables 0, dmem_req 0, flush/bubble 0, mem_timeout = 1.
  - Held until reset; all inputs ignored.
- dmem_ack with no request (RUN, !mem_acc) is ignored.
- dmem_req never drops before ack except on reset or entry to ERR.
- stall_cycles: +1 on each clock edge where pc_en = 0 and state is RUN or MEM_WAIT. Saturates at 2^CNT_W-1. Frozen in ERR.
- Reset mid-operation: state returns to RUN asynchronously, so dmem_req deasserts in the same instant.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rn=3 -> for one cycle: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; stall_cycles 0->1. Next cycle (ex_memread=0) all enables 1.
- No false hazard:
  - ex_rd=31, id_rn=31, ex_memread=1 -> no stall.
  - ex_rd=5, id_rm=5, id_use_rm=0 -> no stall.
- Memory wait: mem_memread=1 held, dmem_ack on 3rd cycle ->
  - dmem_req high 3 cycles;
  - enables 0 and memwb_bubble 1 for cycles 1–2;
  - enables 1 on cycle 3;
  - stall_cycles +=2; state RUN after.
- Timeout with TIMEOUT=4, mem_memwrite=1, no ack -> MEM_WAIT 4 cycles, then ERR: mem_timeout=1, dmem_req=0, enables 0, persisting. rst_n pulse clears to RUN, mem_timeout=0.
- Branch vs load-use: mem_branch_taken=1 with load_use true -> ifid_flush=idex_bubble=exmem_flush=1, pc_en=1, stall_cycles unchanged.
- Async reset mid-MEM_WAIT: rst_n=0 between edges -> dmem_req=0 and enables 1 immediately, stall_cycles=0.
